// File: rtl/variable_delay_if.sv
// Handshake bundle for variable_delay: enable/flush control, delay select, sample in, delayed sample out.
// Latency and backpressure are defined by the attached delay line (no ready path; the producer drives en).
interface variable_delay_if #(
    parameter int WIDTH      = 8,
    parameter int MAX_CYCLES = 16
);
    localparam int DW = $clog2(MAX_CYCLES + 1);

    logic             en;
    logic             flush;
    logic [DW-1:0]    delay;
    logic [WIDTH-1:0] in;
    logic [WIDTH-1:0] out;
    logic             out_valid;

    modport master (output en, flush, delay, in, input out, out_valid);
    modport slave  (input en, flush, delay, in, output out, out_valid);
endinterface

// File: rtl/variable_delay.sv
// Runtime-programmable enable-gated delay line on a circular buffer; out lags in by D enables (D=1: next edge).
// No backpressure: one sample per en cycle at any delay; out/out_valid are flops and hold between enables.
module variable_delay #(
    parameter int WIDTH      = 8,
    parameter int MAX_CYCLES = 16
) (
    input  logic             clk,
    input  logic             rst,
    variable_delay_if.slave  bus
);
    localparam int DW = $clog2(MAX_CYCLES + 1);
    localparam int PW = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;
    localparam logic [DW-1:0] MAX_D    = DW'(MAX_CYCLES);
    localparam logic [PW-1:0] LAST_PTR = PW'(MAX_CYCLES - 1);

    logic [WIDTH-1:0] mem [MAX_CYCLES];

    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [DW-1:0]    fill_q, fill_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic             vld_q, vld_d;

    logic [DW-1:0]    eff_d;
    logic [DW-1:0]    lag;
    logic [DW:0]      rd_sum;
    logic [PW-1:0]    rd_ptr;
    logic             wr_en;

    always_comb begin
        eff_d = bus.delay;
        if (bus.delay == '0) begin
            eff_d = DW'(1);
        end else if (bus.delay > MAX_D) begin
            eff_d = MAX_D;
        end
    end

    // Modular subtraction done explicitly so non-power-of-two depths wrap correctly.
    always_comb begin
        lag = eff_d - DW'(1);
        if ((DW+1)'(wr_ptr_q) >= (DW+1)'(lag)) begin
            rd_sum = (DW+1)'(wr_ptr_q) - (DW+1)'(lag);
        end else begin
            rd_sum = (DW+1)'(wr_ptr_q) + (DW+1)'(MAX_CYCLES) - (DW+1)'(lag);
        end
        rd_ptr = PW'(rd_sum);
    end

    assign wr_en = bus.en && !bus.flush;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        fill_d   = fill_q;
        out_d    = out_q;
        vld_d    = vld_q;
        if (bus.flush) begin
            wr_ptr_d = '0;
            fill_d   = '0;
            out_d    = '0;
            vld_d    = 1'b0;
        end else if (bus.en) begin
            wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + PW'(1);
            fill_d   = (fill_q == MAX_D) ? fill_q : fill_q + DW'(1);
            if (eff_d == DW'(1)) begin
                out_d = bus.in;
            end else if (fill_q >= lag) begin
                out_d = mem[rd_ptr];
            end else begin
                out_d = '0;
            end
            vld_d = (fill_q >= lag);
        end
    end

    // Storage carries no reset; fill gating keeps stale entries unreachable.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr_q] <= bus.in;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            fill_q   <= '0;
            out_q    <= '0;
            vld_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            fill_q   <= fill_d;
            out_q    <= out_d;
            vld_q    <= vld_d;
        end
    end

    assign bus.out       = out_q;
    assign bus.out_valid = vld_q;
endmodule

// File: tb/tb_variable_delay.sv
// Directed bench for variable_delay: hand-computed vector table plus model-checked multi-cycle sequences.
module tb_variable_delay;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    variable_delay_if #(.WIDTH(8), .MAX_CYCLES(16)) bus_a ();
    variable_delay_if #(.WIDTH(8), .MAX_CYCLES(12)) bus_b ();

    variable_delay #(.WIDTH(8), .MAX_CYCLES(16)) dut_a (.clk(clk), .rst(rst), .bus(bus_a.slave));
    variable_delay #(.WIDTH(8), .MAX_CYCLES(12)) dut_b (.clk(clk), .rst(rst), .bus(bus_b.slave));

    typedef struct {
        logic       en;
        logic       fl;
        logic [4:0] dly;
        logic [7:0] din;
        logic [7:0] eout;
        logic       evld;
    } vec_t;

    vec_t       tv[$];
    int         n_checks = 0;
    int         n_fail   = 0;
    logic [7:0] hist_a[$];
    logic [7:0] hist_b[$];
    logic [7:0] exp_a = 8'h00;
    logic [7:0] exp_b = 8'h00;
    logic       ev_a  = 1'b0;
    logic       ev_b  = 1'b0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [8:0] act, input logic [8:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got valid/out=%b/%h, expected %b/%h", name, act[8], act[7:0], exp[8], exp[7:0]);
        end
    endtask

    function automatic int eff(input int d, input int maxc);
        if (d == 0) return 1;
        if (d > maxc) return maxc;
        return d;
    endfunction

    task automatic add(input logic en, input logic fl, input logic [4:0] dly,
                       input logic [7:0] din, input logic [7:0] eout, input logic evld);
        vec_t v;
        v.en = en; v.fl = fl; v.dly = dly; v.din = din; v.eout = eout; v.evld = evld;
        tv.push_back(v);
    endtask

    task automatic step_a(input string name, input logic en, input logic fl, input int d, input logic [7:0] din);
        int idx;
        bus_a.en = en; bus_a.flush = fl; bus_a.delay = 5'(d); bus_a.in = din;
        tick();
        if (fl) begin
            hist_a.delete(); exp_a = 8'h00; ev_a = 1'b0;
        end else if (en) begin
            hist_a.push_back(din);
            idx = hist_a.size() - eff(d, 16);
            if (idx >= 0) begin exp_a = hist_a[idx]; ev_a = 1'b1; end
            else begin exp_a = 8'h00; ev_a = 1'b0; end
        end
        chk(name, {bus_a.out_valid, bus_a.out}, {ev_a, exp_a});
    endtask

    task automatic step_b(input string name, input logic en, input logic fl, input int d, input logic [7:0] din);
        int idx;
        bus_b.en = en; bus_b.flush = fl; bus_b.delay = 4'(d); bus_b.in = din;
        tick();
        if (fl) begin
            hist_b.delete(); exp_b = 8'h00; ev_b = 1'b0;
        end else if (en) begin
            hist_b.push_back(din);
            idx = hist_b.size() - eff(d, 12);
            if (idx >= 0) begin exp_b = hist_b[idx]; ev_b = 1'b1; end
            else begin exp_b = 8'h00; ev_b = 1'b0; end
        end
        chk(name, {bus_b.out_valid, bus_b.out}, {ev_b, exp_b});
    endtask

    initial begin
        bus_a.en = 0; bus_a.flush = 0; bus_a.delay = '0; bus_a.in = '0;
        bus_b.en = 0; bus_b.flush = 0; bus_b.delay = '0; bus_b.in = '0;

        // delay 4, continuous enable
        add(1, 0, 4, 8'h01, 8'h00, 0);
        add(1, 0, 4, 8'h02, 8'h00, 0);
        add(1, 0, 4, 8'h03, 8'h00, 0);
        add(1, 0, 4, 8'h04, 8'h01, 1);
        add(1, 0, 4, 8'h05, 8'h02, 1);
        add(1, 0, 4, 8'h06, 8'h03, 1);
        add(1, 1, 4, 8'hEE, 8'h00, 0);
        // delay 3, alternating enable; delay change while idle must not disturb out
        add(1, 0, 3, 8'h10, 8'h00, 0);
        add(0, 0, 3, 8'h99, 8'h00, 0);
        add(1, 0, 3, 8'h11, 8'h00, 0);
        add(0, 0, 3, 8'h98, 8'h00, 0);
        add(1, 0, 3, 8'h12, 8'h10, 1);
        add(0, 0, 1, 8'h97, 8'h10, 1);
        add(1, 0, 3, 8'h13, 8'h11, 1);
        add(0, 0, 3, 8'h96, 8'h11, 1);
        add(1, 0, 3, 8'h14, 8'h12, 1);
        add(1, 1, 3, 8'hEE, 8'h00, 0);
        // delay 0 behaves as 1
        add(1, 0, 0, 8'hA5, 8'hA5, 1);
        add(1, 0, 0, 8'h5A, 8'h5A, 1);
        add(0, 0, 0, 8'h33, 8'h5A, 1);

        repeat (2) @(posedge clk);
        #1;
        chk("reset_a", {bus_a.out_valid, bus_a.out}, 9'h000);
        chk("reset_b", {bus_b.out_valid, bus_b.out}, 9'h000);
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < tv.size(); i++) begin
            bus_a.en = tv[i].en; bus_a.flush = tv[i].fl; bus_a.delay = tv[i].dly; bus_a.in = tv[i].din;
            tick();
            chk($sformatf("vec%0d", i), {bus_a.out_valid, bus_a.out}, {tv[i].evld, tv[i].eout});
        end

        // delay 31 clamps to 16
        step_a("d31_flush", 1, 1, 31, 8'h00);
        for (int i = 1; i <= 17; i++) step_a($sformatf("d31_%0d", i), 1, 0, 31, 8'(8'h20 + i));
        chk("d31_second", {bus_a.out_valid, bus_a.out}, {1'b1, 8'h22});

        // 20 samples at D=8, then switch to D=3
        step_a("d8_flush", 1, 1, 8, 8'h00);
        for (int i = 1; i <= 20; i++) step_a($sformatf("d8_%0d", i), 1, 0, 8, 8'(8'h40 + i));
        step_a("d3_sw", 1, 0, 3, 8'h55);
        chk("d3_sw_val", {bus_a.out_valid, bus_a.out}, {1'b1, 8'h53});
        step_a("d3_sw2", 1, 0, 3, 8'h56);

        // mid-stream flush with en=1, refill at D=5, then grow to D=16 after 10 enables
        step_a("fl_mid", 1, 1, 5, 8'hEE);
        chk("fl_mid_val", {bus_a.out_valid, bus_a.out}, 9'h000);
        for (int i = 1; i <= 10; i++) begin
            step_a($sformatf("d5_%0d", i), 1, 0, 5, 8'(8'h60 + i));
            if (i == 5) chk("d5_first", {bus_a.out_valid, bus_a.out}, {1'b1, 8'h61});
        end
        for (int i = 11; i <= 17; i++) begin
            step_a($sformatf("d16_%0d", i), 1, 0, 16, 8'(8'h60 + i));
            if (i == 15) chk("d16_gap", {bus_a.out_valid, bus_a.out}, 9'h000);
            if (i == 16) chk("d16_first", {bus_a.out_valid, bus_a.out}, {1'b1, 8'h61});
        end

        // asynchronous reset between edges
        step_a("ar_1", 1, 0, 2, 8'h71);
        step_a("ar_2", 1, 0, 2, 8'h72);
        bus_a.en = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        chk("arst_clear", {bus_a.out_valid, bus_a.out}, 9'h000);
        hist_a.delete(); exp_a = 8'h00; ev_a = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        step_a("post_rst_1", 1, 0, 2, 8'h81);
        step_a("post_rst_2", 1, 0, 2, 8'h82);
        bus_a.en = 1'b0;

        // non-power-of-two depth wrap, D=12 over 30 enables
        for (int i = 1; i <= 30; i++) begin
            step_b($sformatf("b12_%0d", i), 1, 0, 12, 8'(8'h80 + i));
            if (i == 11) chk("b12_pre", {bus_b.out_valid, bus_b.out}, 9'h000);
            if (i == 12) chk("b12_first", {bus_b.out_valid, bus_b.out}, {1'b1, 8'h81});
            if (i == 30) chk("b12_last", {bus_b.out_valid, bus_b.out}, {1'b1, 8'h93});
        end
        step_b("b12_idle", 0, 0, 5, 8'hFF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/variable_delay.md
# variable_delay

Runtime-programmable, enable-gated delay line built on a circular buffer instead of a register chain. Each `en` cycle captures one `in` sample. `out` presents the sample captured `delay` enable-cycles earlier, which is bit-identical to a chain of `delay` reset-to-zero registers sharing the same enable. The block sits in datapaths that must align streams whose relative latency is set at run time, and it reports whether the sample on `out` is real data or reset fill.

## Interface
- `WIDTH`, 8, data width in bits
- `MAX_CYCLES`, 16, largest supported delay; ≥ 2; buffer depth
- `DW`, `$clog2(MAX_CYCLES+1)`, width of `delay` (localparam)

- `clk`  in  1  clock; all state updates on rising edge
- `rst`  in  1  asynchronous, active-low reset; asserts immediately, deasserts synchronously to `clk` upstream
- `en`  in  1  advance: capture `in`, update `out`/`out_valid`
- `flush`  in  1  synchronous clear of history; priority over `en`
- `delay`  in  DW  requested delay in enable-cycles; sampled every `en` cycle
- `in`  in  WIDTH  sample to capture
- `out`  out  WIDTH  delayed sample, registered
- `out_valid`  out  1  `out` holds a sample captured since the last reset/flush

## Operation
- Effective delay `D`:
  - `delay` = 0 gives D = 1.
  - `delay` > `MAX_CYCLES` gives D = `MAX_CYCLES`.
  - Otherwise D = `delay`.
- State:
  - `mem[MAX_CYCLES]` of WIDTH; not reset.
  - `wr_ptr` in 0..MAX_CYCLES-1; wraps MAX_CYCLES-1 → 0.
  - `fill` in 0..MAX_CYCLES; saturating count of enables since reset/flush.
- On an `en` cycle (`flush` = 0):
  - `mem[wr_ptr]` <= `in`; `wr_ptr` advances with wrap; `fill` <= min(`fill`+1, MAX_CYCLES).
  - If D = 1: `out` <= `in`.
  - Else if `fill` ≥ D-1: `out` <= `mem[(wr_ptr - (D-1)) mod MAX_CYCLES]`. Modular subtraction must be correct for non-power-of-two MAX_CYCLES.
  - Else: `out` <= 0. The addressed sample predates reset/flush, which matches a zeroed register chain.
  - `out_valid` <= (`fill` + 1 ≥ D).
- `en` = 0: all state holds. `out` and `out_valid` never change between enables, even if `delay` changes.
- `flush` = 1:
  - `wr_ptr` <= 0, `fill` <= 0, `out` <= 0, `out_valid` <= 0.
  - Input sample is discarded even if `en` = 1.
- Changing `delay` mid-stream: the next enable uses the new D against existing history, with no gap or bubble. If the new D exceeds `fill`+1, `out` = 0 and `out_valid` = 0 until history suffices.
- Reset (any time, including mid-stream): `out` = 0, `out_valid` = 0, `wr_ptr` = 0, `fill` = 0. `mem` contents are unreachable until rewritten, because the `fill` check gates them.

## Timing
- Latency: the sample captured at enable edge k appears on `out` at enable edge k+D-1, i.e. D enable-cycles after presentation, counting the capture edge.
- `out` and `out_valid` are pure flops with no combinational path from any input.
- Read and write occur at the same edge. The read address never equals `wr_ptr` when D ≥ 2, so there is no read-during-write hazard.
- Back-to-back `en` sustains one sample per clock at any D.
- Reset-to-first-valid: the first `out_valid` = 1 occurs on the D-th enable after reset/flush.

## Test plan
- `delay` = 4, `en` = 1 continuously, `in` = 1,2,3,…: `out` = 0,0,0,1,2,3…. `out_valid` rises on the edge where `out` becomes 1.
- `delay` = 3, `en` toggled 1,0,1,0…: `out` changes only on `en` edges and equals the value presented 3 enables earlier. It is held on idle cycles.
- `delay` = 0, `in` = 0xA5 → next edge `out` = 0xA5, `out_valid` = 1. `delay` = 31 with MAX_CYCLES = 16 → behaves as D = 16.
- Stream 20 samples at D = 8, then switch to D = 3 → the next `out` is the sample from 3 enables back. Switch to D = 16 after only 10 enables since flush → `out` = 0, `out_valid` = 0 until the 16th enable.
- Assert `flush` with `en` = 1 mid-stream → `out` = 0, `out_valid` = 0, input dropped. Refill at D = 5 → first valid output is the first post-flush sample, on the 5th enable.
- Drop `rst` low asynchronously mid-stream between clock edges → `out`/`out_valid` clear immediately. After release, the wrap-around past `wr_ptr` = MAX_CYCLES-1 with MAX_CYCLES = 12 (non-power-of-two) gives correct samples for D = 12 over 30 enables.
